// File: rtl/adc_spi_master.sv
// Byte-wide SPI master for the ADC configuration port: shifts one command byte
// out on MOSI while capturing the byte returned on MISO.
//
// state | meaning
// IDLE  | waiting for an accepted transmit request, SCLK parked at CPOL
// SHIFT | generating 16 SCLK edges, driving MOSI and sampling MISO
// DONE  | one cycle: received byte published, ready for the next byte
module adc_spi_master #(
  parameter int CLKS_PER_HALF_BIT = 4,
  parameter int SPI_MODE          = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_dv,
  output logic       o_tx_ready,
  output logic       o_rx_dv,
  output logic [7:0] o_rx_byte,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic CPOL = ((SPI_MODE >> 1) & 1) != 0;
  localparam logic CPHA = (SPI_MODE & 1) != 0;
  localparam int   HB_W = (CLKS_PER_HALF_BIT > 2) ? $clog2(CLKS_PER_HALF_BIT) : 1;
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(CLKS_PER_HALF_BIT - 1);

  if (SPI_MODE < 0 || SPI_MODE > 3 || CLKS_PER_HALF_BIT < 2) begin : g_bad_param
    $error("adc_spi_master: illegal SPI_MODE or CLKS_PER_HALF_BIT");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [HB_W-1:0] hb_q, hb_d;
  logic [4:0]      edge_q, edge_d, edge_next;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            tx_ready_q, tx_ready_d;
  logic            rx_dv_q, rx_dv_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            leading;

  always_comb begin
    state_d    = state_q;
    hb_d       = hb_q;
    edge_d     = edge_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    tx_ready_d = tx_ready_q;
    rx_dv_d    = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    edge_next  = edge_q + 5'd1;
    leading    = edge_next[0];

    case (state_q)
      IDLE, DONE: begin
        if (i_tx_dv && tx_ready_q) begin
          state_d    = SHIFT;
          tx_shift_d = i_tx_byte;
          hb_d       = '0;
          edge_d     = '0;
          tx_ready_d = 1'b0;
          if (!CPHA) mosi_d = i_tx_byte[7];
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (hb_q == HB_LAST) begin
          hb_d   = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_next;
          // CPHA=0 samples on leading edges, CPHA=1 on trailing edges
          if (leading != CPHA) rx_shift_d = {rx_shift_q[6:0], spi_miso};
          if (CPHA && leading) begin
            mosi_d     = tx_shift_q[7];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end else if (!CPHA && !leading && edge_next != 5'd16) begin
            mosi_d     = tx_shift_q[6];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
          if (edge_next == 5'd16) begin
            state_d    = DONE;
            rx_byte_d  = rx_shift_d;
            rx_dv_d    = 1'b1;
            tx_ready_d = 1'b1;
          end
        end else begin
          hb_d = hb_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      hb_q       <= '0;
      edge_q     <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      tx_ready_q <= 1'b1;
      rx_dv_q    <= 1'b0;
      sclk_q     <= CPOL;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hb_q       <= hb_d;
      edge_q     <= edge_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      tx_ready_q <= tx_ready_d;
      rx_dv_q    <= rx_dv_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
    end
  end

  assign o_tx_ready = tx_ready_q;
  assign o_rx_dv    = rx_dv_q;
  assign o_rx_byte  = rx_byte_q;
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;

endmodule
